// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Refills 4-word lines one word at a time from a single-word memory bus.
module dcache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_Dcache_i,
  input  logic        mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [1:0]  mem_wrwidth_i,
  input  logic [31:0] mem_wr_data_i,
  output logic [31:0] dcache_rd_data_o,
  output logic        dcache_stall_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_wstrb_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned TagW = 28 - IDX_W;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [LINES-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  logic [IDX_W-1:0]  idx;
  logic [TagW-1:0]   tag;
  logic [1:0]        word;
  logic              hit;
  logic [3:0]        strb;
  logic [31:0]       wdata;

  assign idx  = mem_addr_i[IDX_W+3:4];
  assign tag  = mem_addr_i[31:IDX_W+4];
  assign word = mem_addr_i[3:2];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  // Store lane formatting; misaligned addresses are force-aligned.
  always_comb begin
    strb  = 4'b1111;
    wdata = mem_wr_data_i;
    unique case (mem_wrwidth_i)
      2'b00: begin
        strb  = 4'b0001 << mem_addr_i[1:0];
        wdata = {4{mem_wr_data_i[7:0]}};
      end
      2'b01: begin
        strb  = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_wr_data_i[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = mem_wr_data_i;
      end
    endcase
  end

  // Control state; only valid bits are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        cnt_q <= 2'd0;
      end else if (state_q == StRefill && ram_ack_i) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          valid_q[idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StRefill && ram_ack_i) begin
        data_q[idx][cnt_q] <= ram_rdata_i;
        if (cnt_q == 2'd3) begin
          tag_q[idx] <= tag;
        end
      end else if (state_q == StWrite && ram_ack_i && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            data_q[idx][word][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_Dcache_i) begin
          if (mem_rw_i) begin
            state_d = StWrite;
          end else if (!hit) begin
            state_d = StRefill;
          end
        end
      end
      StRefill: if (ram_ack_i && cnt_q == 2'd3) state_d = StIdle;
      StWrite:  if (ram_ack_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    dcache_rd_data_o = '0;
    dcache_stall_o   = 1'b0;
    ram_req_o        = 1'b0;
    ram_we_o         = 1'b0;
    ram_addr_o       = '0;
    ram_wstrb_o      = '0;
    ram_wdata_o      = '0;
    unique case (state_q)
      StIdle: begin
        if (mem_req_Dcache_i) begin
          if (mem_rw_i || !hit) begin
            dcache_stall_o = 1'b1;
          end else begin
            dcache_rd_data_o = data_q[idx][word];
          end
        end
      end
      StRefill: begin
        ram_req_o      = 1'b1;
        ram_addr_o     = {mem_addr_i[31:4], cnt_q, 2'b00};
        dcache_stall_o = 1'b1;
      end
      StWrite: begin
        ram_req_o      = 1'b1;
        ram_we_o       = 1'b1;
        ram_addr_o     = {mem_addr_i[31:2], 2'b00};
        ram_wstrb_o    = strb;
        ram_wdata_o    = wdata;
        dcache_stall_o = ~ram_ack_i;
      end
      default: begin
        dcache_stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a bus memory model answers refills and stores,
// expected load data comes from a separate reference memory updated by the stimulus.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, rw;
  logic [31:0] addr;
  logic [1:0]  width;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  dcache #(.LINES(16), .IDX_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_Dcache_i (req),
    .mem_rw_i         (rw),
    .mem_addr_i       (addr),
    .mem_wrwidth_i    (width),
    .mem_wr_data_i    (wr_data),
    .dcache_rd_data_o (rd_data),
    .dcache_stall_o   (stall),
    .ram_req_o        (ram_req),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_wstrb_o      (ram_wstrb),
    .ram_wdata_o      (ram_wdata),
    .ram_ack_i        (ram_ack),
    .ram_rdata_i      (ram_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;
  logic [31:0] bus_word;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (w)
      2'b00:   r[8*a[1:0] +: 8] = d[7:0];
      2'b01:   r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Bus memory: acks after ack_delay idle request cycles, updated from strobed writes.
  always @(negedge clk) begin
    if (ram_req) begin
      if (wait_cnt == ack_delay) begin
        ram_ack  = 1'b1;
        wait_cnt = 0;
        if (ram_we) begin
          bus_word = bus_rd(ram_addr);
          for (int b = 0; b < 4; b++) begin
            if (ram_wstrb[b]) bus_word[8*b +: 8] = ram_wdata[8*b +: 8];
          end
          bmem[ram_addr] = bus_word;
        end else begin
          ram_rdata = bus_rd(ram_addr);
        end
      end else begin
        ram_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      ram_ack   = 1'b0;
      ram_rdata = '0;
      wait_cnt  = 0;
    end
  end

  // One access; called just after a rising edge. Returns the number of stalled cycles.
  task automatic access(input logic r, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] d, output int stalls);
    logic [31:0] e;
    bit          done;
    done = 0;
    req = 1'b1; rw = r; addr = a; width = w; wr_data = d;
    seen_addr = 'x; seen_strb = 'x; seen_wdata = 'x;
    if (!r) exp_q.push_back(ref_rd({a[31:2], 2'b00}));
    else rmem[{a[31:2], 2'b00}] = ref_merge(ref_rd({a[31:2], 2'b00}), a, w, d);
    stalls = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #2;
      if (ram_req && ram_we) begin
        seen_addr = ram_addr; seen_strb = ram_wstrb; seen_wdata = ram_wdata;
      end
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
      vectors++;
      if (rd_data !== 32'h0) begin
        miscompares++;
        $display("FAIL rd_data_during_stall addr=%h got %h want 00000000", a, rd_data);
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL access_timeout addr=%h stall still %b want 0", a, stall);
      if (!r) void'(exp_q.pop_front());
    end else if (!r) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_data !== e) begin
        miscompares++;
        $display("FAIL load_data addr=%h got %h want %h", a, rd_data, e);
      end
    end else begin
      vectors++;
      if (rd_data !== 32'h0) begin
        miscompares++;
        $display("FAIL rd_data_on_store addr=%h got %h want 00000000", a, rd_data);
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic check_stalls(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_write(input string name, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
    vectors++;
    if (seen_addr !== a || seen_strb !== s || seen_wdata !== d) begin
      miscompares++;
      $display("FAIL %s bus got addr=%h strb=%b wdata=%h want addr=%h strb=%b wdata=%h",
               name, seen_addr, seen_strb, seen_wdata, a, s, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; width = 2'b10; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    vectors++;
    if (stall !== 1'b0 || ram_req !== 1'b0 || rd_data !== 32'h0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got stall=%b ram_req=%b ram_we=%b rd=%h want 0 0 0 0",
               stall, ram_req, ram_we, rd_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_load();
    int s;
    for (int i = 0; i < 4; i++) begin
      bmem[32'h100 + 4*i] = 32'hA0 + i;
      rmem[32'h100 + 4*i] = 32'hA0 + i;
    end
    access(1'b0, 32'h0000_0104, 2'b10, '0, s);
    check_stalls("cold_load", s, 5);
    access(1'b0, 32'h0000_0108, 2'b10, '0, s);
    check_stalls("hit_after_refill", s, 0);
  endtask

  task automatic test_store_hit();
    int s;
    access(1'b1, 32'h0000_0106, 2'b00, 32'h0000_005C, s);
    check_stalls("store_byte", s, 1);
    check_write("store_byte", 32'h104, 4'b0100, 32'h5C5C5C5C);
    access(1'b0, 32'h0000_0104, 2'b10, '0, s);
    check_stalls("load_after_store_hit", s, 0);
  endtask

  task automatic test_store_miss();
    int s;
    access(1'b1, 32'h0000_2002, 2'b01, 32'h1234_BEEF, s);
    check_stalls("store_half_miss", s, 1);
    check_write("store_half_miss", 32'h2000, 4'b1100, 32'hBEEFBEEF);
    access(1'b0, 32'h0000_2000, 2'b10, '0, s);
    check_stalls("no_allocate", s, 5);
  endtask

  task automatic test_conflict();
    int s;
    access(1'b0, 32'h0000_0100, 2'b10, '0, s);
    check_stalls("conflict_first", s, 5);
    access(1'b0, 32'h0000_0100, 2'b10, '0, s);
    check_stalls("conflict_rehit", s, 0);
    access(1'b0, 32'h0000_1100, 2'b10, '0, s);
    check_stalls("conflict_evict", s, 5);
    access(1'b0, 32'h0000_0100, 2'b10, '0, s);
    check_stalls("conflict_reload", s, 5);
  endtask

  task automatic test_delayed_ack();
    int s;
    ack_delay = 3;
    access(1'b0, 32'h0000_4040, 2'b10, '0, s);
    check_stalls("delayed_refill", s, 17);
    ack_delay = 0;
    access(1'b0, 32'h0000_404C, 2'b10, '0, s);
    check_stalls("delayed_line_hit", s, 0);
  endtask

  task automatic test_back_to_back();
    int s;
    access(1'b1, 32'h0000_4048, 2'b10, 32'hCAFE_F00D, s);
    check_write("store_word", 32'h4048, 4'b1111, 32'hCAFEF00D);
    access(1'b0, 32'h0000_4048, 2'b10, '0, s);
    check_stalls("word_store_hit_load", s, 0);
    access(1'b1, 32'h0000_404F, 2'b11, 32'h1357_9BDF, s);
    check_write("width3_misaligned", 32'h404C, 4'b1111, 32'h13579BDF);
    access(1'b1, 32'h0000_4041, 2'b01, 32'h0000_A55A, s);
    check_write("half_odd_addr", 32'h4040, 4'b0011, 32'hA55AA55A);
    access(1'b0, 32'h0000_404C, 2'b10, '0, s);
    access(1'b0, 32'h0000_4040, 2'b10, '0, s);
    check_stalls("merged_line_hit", s, 0);
  endtask

  task automatic test_reset_mid();
    int  s;
    int  acks;
    bit  done;
    acks = 0; done = 0;
    req = 1'b1; rw = 1'b0; addr = 32'h0000_3000; width = 2'b10;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #2;
      if (ram_ack) acks++;
      if (acks == 2) begin
        done = 1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL reset_mid_acks got %0d want 2", acks);
    end
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #2;
    vectors++;
    if (stall !== 1'b0 || ram_req !== 1'b0 || rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got stall=%b ram_req=%b rd=%h want 0 0 0",
               stall, ram_req, rd_data);
    end
    @(posedge clk); #1;
    access(1'b0, 32'h0000_3000, 2'b10, '0, s);
    check_stalls("reload_after_reset", s, 5);
    access(1'b0, 32'h0000_0104, 2'b10, '0, s);
    check_stalls("valid_cleared", s, 5);
  endtask

  initial begin
    ram_ack = 1'b0;
    ram_rdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_delayed_ack();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
